// File: rtl/cozy_dma_pkg.sv
// Shared definitions for the cozy_dma copy engine: byte-write-enable codes and FSM states.
package cozy_dma_pkg;

  localparam logic [1:0] BWE_NONE = 2'b00;
  localparam logic [1:0] BWE_BYTE = 2'b01;
  localparam logic [1:0] BWE_WORD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  // Byte transfers only carry the low lane; the memory steers it using addr[0].
  function automatic logic [15:0] lane_data(input logic word, input logic [15:0] d);
    return word ? d : {8'h00, d[7:0]};
  endfunction

endpackage

// File: rtl/cozy_dma.sv
// Bus-master copy engine on the cozy memory port: alternating read/write per unit, forward copy.
// Optional COZY_DMA_FILL_EN adds fill/fill_val ports for a write-only pattern fill.
module cozy_dma
  import cozy_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef COZY_DMA_FILL_EN
  input  logic             fill,
  input  logic [15:0]      fill_val,
`endif
  input  logic [15:0]      src,
  input  logic [15:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic             word_mode,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  output logic [1:0]       mem_bwe,
  input  logic [15:0]      mem_rdata
);

  logic        fill_in;
  logic [15:0] fill_data;
`ifdef COZY_DMA_FILL_EN
  assign fill_in   = fill;
  assign fill_data = fill_val;
`else
  assign fill_in   = 1'b0;
  assign fill_data = 16'h0000;
`endif

  state_t           state, state_d;
  logic [15:0]      src_q, dst_q, data_q;
  logic [LEN_W-1:0] cnt_q;
  logic             word_q, fill_q, rd_fresh;
  logic             accept, misalign, go, last, wr_fire;
  logic [15:0]      wsrc, astep;
  logic [LEN_W-1:0] cstep;

  // Fill never reads, so the source address alignment is irrelevant there.
  assign misalign = word_mode & (dst[0] | len[0] | (~fill_in & src[0]));
  assign accept   = (state == S_IDLE) & start;
  assign go       = accept & ~misalign & (len != '0);

  assign astep = {14'b0, word_q, ~word_q};
  assign cstep = {{(LEN_W-2){1'b0}}, word_q, ~word_q};
  assign last  = (cnt_q <= cstep);

  // Read data is only valid for one cycle; the first WR cycle forwards it directly,
  // later (stalled) WR cycles use the captured copy.
  assign wsrc = rd_fresh ? mem_rdata : data_q;

  assign busy    = (state != S_IDLE);
  assign mem_req = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    mem_bwe   = BWE_NONE;
    wr_fire   = 1'b0;
    case (state)
      S_IDLE: if (go) state_d = fill_in ? S_WR : S_RD;
      S_RD: if (mem_gnt) begin
        mem_addr = src_q;
        state_d  = S_WR;
      end
      S_WR: if (mem_gnt) begin
        mem_addr  = dst_q;
        mem_wdata = lane_data(word_q, wsrc);
        mem_bwe   = word_q ? BWE_WORD : BWE_BYTE;
        wr_fire   = 1'b1;
        if (last)        state_d = S_IDLE;
        else if (fill_q) state_d = S_WR;
        else             state_d = S_RD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      word_q   <= 1'b0;
      fill_q   <= 1'b0;
      rd_fresh <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rd_fresh <= (state == S_RD) & mem_gnt;
      if (rd_fresh) data_q <= mem_rdata;
      if (accept) begin
        if (misalign)         err  <= 1'b1;
        else if (len == '0)   done <= 1'b1;
        else begin
          src_q  <= src;
          dst_q  <= dst;
          cnt_q  <= len;
          word_q <= word_mode;
          fill_q <= fill_in;
          data_q <= fill_data;
        end
      end
      if (wr_fire) begin
        src_q <= src_q + astep;
        dst_q <= dst_q + astep;
        cnt_q <= cnt_q - cstep;
        if (last) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cozy_dma.sv
// Directed bench for cozy_dma with a byte-addressed memory model on the cozy port.
module tb_cozy_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src = '0, dst = '0, len = '0;
  logic        word_mode = 1'b0;
  logic        busy, done, err, mem_req;
  logic        mem_gnt = 1'b1;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_bwe;
`ifdef COZY_DMA_FILL_EN
  logic        fill = 1'b0;
  logic [15:0] fill_val = '0;
`endif

  int nchk = 0, nerr = 0;
  int viol = 0, reqc = 0;
  logic        stall = 1'b0;
  logic [15:0] rdq[$], wrq[$];
  logic [1:0]  wbq[$];
  logic [7:0]  m[0:65535];

  always #5 clk = ~clk;

  cozy_dma #(.LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef COZY_DMA_FILL_EN
    .fill(fill), .fill_val(fill_val),
`endif
    .src(src), .dst(dst), .len(len), .word_mode(word_mode),
    .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_bwe(mem_bwe), .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] pat(input int a);
    return 8'(a * 7 + 3);
  endfunction

  // Memory: read data registered (valid the cycle after the address), odd byte reads shifted down.
  always @(posedge clk) begin
    mem_rdata <= mem_addr[0] ? {8'h00, m[mem_addr]} : {m[mem_addr | 16'd1], m[mem_addr]};
    if (mem_bwe == 2'b11) begin
      m[mem_addr]         = mem_wdata[7:0];
      m[mem_addr | 16'd1] = mem_wdata[15:8];
    end else if (mem_bwe == 2'b01) begin
      m[mem_addr] = mem_wdata[7:0];
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_gnt && mem_bwe == 2'b00) rdq.push_back(mem_addr);
      if (mem_req && mem_gnt && mem_bwe != 2'b00) begin
        wrq.push_back(mem_addr);
        wbq.push_back(mem_bwe);
      end
      if (!(mem_req && mem_gnt) && (mem_addr != 0 || mem_wdata != 0 || mem_bwe != 0)) viol++;
      if (mem_req) reqc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a start and watch until done (bounded); stall drops gnt in cycles 3-5 and 7-9.
  task automatic run(input logic [15:0] s, d, l, input logic w, input int maxc,
                     output int dc, output int bc, output int ecy);
    rdq.delete(); wrq.delete(); wbq.delete();
    viol = 0; reqc = 0;
    @(posedge clk); #1;
    start = 1'b1; src = s; dst = d; len = l; word_mode = w;
    @(posedge clk); #1;
    start = 1'b0;
    dc = -1; bc = 0; ecy = -1;
    for (int i = 1; i <= maxc; i++) begin
      mem_gnt = !(stall && ((i >= 3 && i <= 5) || (i >= 7 && i <= 9)));
      @(negedge clk);
      if (busy) bc++;
      if (err && ecy < 0) ecy = i;
      if (done) begin dc = i; break; end
      @(posedge clk); #1;
    end
    mem_gnt = 1'b1;
  endtask

  int dc, bc, ecy, dcount;

  initial begin
    for (int i = 0; i < 65536; i++) m[i] = pat(i);
    #12;
    chk("reset_outputs", {busy, done, err, mem_req, mem_addr, mem_wdata, mem_bwe}, '0);
    @(posedge clk); #1 rst = 1'b0;

    // Word copy 0x10 -> 0x40, 6 bytes
    run(16'h0010, 16'h0040, 16'd6, 1'b1, 20, dc, bc, ecy);
    chk("word_done_cycle", dc, 7);
    chk("word_busy_cycles", bc, 6);
    chk("word_nreads", rdq.size(), 3);
    chk("word_nwrites", wrq.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("word_rd_addr", rdq[k], 16'h0010 + 16'(2 * k));
      chk("word_wr_addr", wrq[k], 16'h0040 + 16'(2 * k));
      chk("word_wr_bwe", wbq[k], 2'b11);
    end
    for (int k = 0; k < 6; k++) chk("word_data", m[16'h0040 + k], pat(16'h0010 + k));
    chk("word_idle_zero", viol, 0);

    // Byte copy 0x11 -> 0x20, 3 bytes
    run(16'h0011, 16'h0020, 16'd3, 1'b0, 20, dc, bc, ecy);
    chk("byte_done_cycle", dc, 7);
    chk("byte_nwrites", wrq.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("byte_wr_addr", wrq[k], 16'h0020 + 16'(k));
      chk("byte_wr_bwe", wbq[k], 2'b01);
      chk("byte_data", m[16'h0020 + k], pat(16'h0011 + k));
    end
    chk("byte_nbr_lo", m[16'h001F], pat(16'h001F));
    chk("byte_nbr_hi", m[16'h0023], pat(16'h0023));

    // Misaligned word start -> err only
    run(16'h0011, 16'h0040, 16'd4, 1'b1, 4, dc, bc, ecy);
    chk("err_cycle", ecy, 1);
    chk("err_no_done", dc, -1);
    chk("err_no_req", reqc, 0);
    chk("err_no_busy", bc, 0);

    // Zero length -> done only
    run(16'h0010, 16'h0040, 16'd0, 1'b1, 4, dc, bc, ecy);
    chk("len0_done_cycle", dc, 1);
    chk("len0_no_err", ecy, -1);
    chk("len0_no_req", reqc, 0);

    // Grant stalls on the second unit's RD and WR
    stall = 1'b1;
    run(16'h0010, 16'h0060, 16'd6, 1'b1, 30, dc, bc, ecy);
    stall = 1'b0;
    chk("stall_done_cycle", dc, 13);
    chk("stall_busy_cycles", bc, 12);
    chk("stall_outputs_zero", viol, 0);
    for (int k = 0; k < 6; k++) chk("stall_data", m[16'h0060 + k], pat(16'h0010 + k));

    // Address wrap
    run(16'hFFFE, 16'h0100, 16'd4, 1'b1, 20, dc, bc, ecy);
    chk("wrap_done_cycle", dc, 5);
    chk("wrap_rd0", rdq[0], 16'hFFFE);
    chk("wrap_rd1", rdq[1], 16'h0000);
    chk("wrap_d0", m[16'h0100], pat(16'hFFFE));
    chk("wrap_d1", m[16'h0101], pat(16'hFFFF));
    chk("wrap_d2", m[16'h0102], pat(0));
    chk("wrap_d3", m[16'h0103], pat(1));

    // Reset mid-transfer
    @(posedge clk); #1;
    start = 1'b1; src = 16'h0010; dst = 16'h0080; len = 16'd6; word_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_addr", mem_addr, 16'h0012);
    #2 rst = 1'b1;
    #1;
    chk("rst_outputs_zero", {busy, done, err, mem_req, mem_addr, mem_wdata, mem_bwe}, '0);
    @(posedge clk); #1 rst = 1'b0;
    dcount = 0;
    repeat (6) begin @(negedge clk); if (done) dcount++; end
    chk("rst_no_done", dcount, 0);
    chk("rst_partial_kept", m[16'h0082], pat(16'h0082));
    run(16'h0030, 16'h00A0, 16'd2, 1'b1, 20, dc, bc, ecy);
    chk("post_rst_done_cycle", dc, 3);
    chk("post_rst_data", {m[16'h00A1], m[16'h00A0]}, {pat(16'h0031), pat(16'h0030)});

`ifdef COZY_DMA_FILL_EN
    fill = 1'b1; fill_val = 16'hA5A5;
    run(16'h0011, 16'h0200, 16'd4, 1'b1, 20, dc, bc, ecy);
    fill = 1'b0;
    chk("fill_done_cycle", dc, 3);
    chk("fill_no_reads", rdq.size(), 0);
    chk("fill_nwrites", wrq.size(), 2);
    chk("fill_data", {m[16'h0203], m[16'h0202], m[16'h0201], m[16'h0200]}, 32'hA5A5A5A5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
